// File: rtl/key_capture_if.sv
// Keypad scanner signal bundle: row sense in, column drive and results out.
`timescale 1ns/1ps
interface key_capture_if;
   logic [3:0]  row;
   logic [2:0]  col;
   logic [11:0] key;
   logic [11:0] key_save;
   logic        key_valid;
   logic        enter;

   modport master (
      input  row,
      output col, key, key_save, key_valid, enter
   );

   modport slave (
      output row,
      input  col, key, key_save, key_valid, enter
   );
endinterface

// File: rtl/key_capture.sv
// 3x4 keypad scanner with frame debounce and single-accept press FSM.
// Define KEY_CAPTURE_HASH_ENTER_EN to make '#' the enter key.
`timescale 1ns/1ps
module key_capture #(
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned DEB_CNT  = 4
) (
   input logic        clk,
   input logic        reset,
   key_capture_if.master kp
);

   typedef enum logic [1:0] {
      RELEASED, PRESSING, HELD, RELEASING
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  row_s1, row_s2;
   logic [15:0] scan_cnt;
   logic [2:0]  col;
   logic [11:0] raw, prev, frame;
   logic [11:0] key_r, key_nxt, key_save;
   logic [3:0]  stab, stab_nxt;
   logic        col_end, frame_end;
   logic        one_hot, acc, acc_digit;
   logic        key_valid, enter;

   assign col_end   = scan_cnt == 16'(SCAN_DIV - 1);
   assign frame_end = col_end & col[2];
   assign one_hot   = (frame != '0) &&
                      ((frame & (frame - 12'd1)) == '0);

   // Last column is sampled live so the frame is complete at its end.
   always_comb begin
      frame     = raw;
      frame[2]  = row_s2[0];
      frame[5]  = row_s2[1];
      frame[8]  = row_s2[2];
      frame[11] = row_s2[3];
   end

   always_comb begin
      stab_nxt = 4'd1;
      if (frame == prev)
         stab_nxt = (stab >= 4'(DEB_CNT)) ?
                    4'(DEB_CNT) : stab + 4'd1;
   end

   always_comb begin
      state_nxt = state;
      key_nxt   = key_r;
      acc       = 1'b0;
      if (frame_end) begin
         unique case (state)
            RELEASED: begin
               if (one_hot) state_nxt = PRESSING;
            end
            PRESSING: begin
               if (!one_hot || frame != prev) begin
                  state_nxt = RELEASED;
               end else if (stab_nxt == 4'(DEB_CNT)) begin
                  state_nxt = HELD;
                  key_nxt   = frame;
                  acc       = 1'b1;
               end
            end
            HELD: begin
               if (frame != key_r) state_nxt = RELEASING;
            end
            RELEASING: begin
               if (frame == key_r) begin
                  state_nxt = HELD;
               end else if (frame == '0 &&
                            stab_nxt == 4'(DEB_CNT)) begin
                  state_nxt = RELEASED;
                  key_nxt   = '0;
               end
            end
            default: state_nxt = RELEASED;
         endcase
      end
   end

   assign acc_digit = acc & ~key_nxt[9] & ~key_nxt[11];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RELEASED;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_s1    <= '0;
         row_s2    <= '0;
         scan_cnt  <= '0;
         col       <= 3'b001;
         raw       <= '0;
         prev      <= '0;
         stab      <= '0;
         key_r     <= '0;
         key_save  <= '0;
         key_valid <= 1'b0;
         enter     <= 1'b0;
      end else begin
         row_s1 <= kp.row;
         row_s2 <= row_s1;
         if (col_end) begin
            scan_cnt <= '0;
            col      <= {col[1:0], col[2]};
            for (int r = 0; r < 4; r++) begin
               if (col[0]) raw[r*3]     <= row_s2[r];
               if (col[1]) raw[r*3 + 1] <= row_s2[r];
               if (col[2]) raw[r*3 + 2] <= row_s2[r];
            end
         end else begin
            scan_cnt <= scan_cnt + 16'd1;
         end
         if (frame_end) begin
            prev <= frame;
            stab <= stab_nxt;
         end
         key_r     <= key_nxt;
         key_valid <= acc_digit;
         if (acc_digit) key_save <= key_nxt;
`ifdef KEY_CAPTURE_HASH_ENTER_EN
         enter <= acc & key_nxt[11];
`else
         enter <= key_valid;
`endif
      end
   end

   assign kp.col       = col;
   assign kp.key       = key_r;
   assign kp.key_save  = key_save;
   assign kp.key_valid = key_valid;
   assign kp.enter     = enter;

endmodule
